hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_src_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared register-index and forwarding-select constants for the hazard scoreboard
package hazard_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  // fwd_sel encoding: 0 reads the register file, FWD_SEL_STAGE0 + k reads stage k
  localparam int FWD_SEL_RF     = 0;
  localparam int FWD_SEL_STAGE0 = 1;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic int fwd_sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-read-port forwarding select and stall detection
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = 2
) (
  input  logic [REG_W-1:0]         src,
  input  logic                     want,
  input  logic                     need,
  input  logic [NUM_FWD-1:0]       stg_wr,
  input  logic [NUM_FWD*REG_W-1:0] stg_dst,
  input  logic [NUM_FWD-1:0]       stg_rdy,
  input  logic [NUM_REGS-1:0]      pending,
  output logic [SEL_W-1:0]         sel,
  output logic                     stall
);

  logic             hit;
  logic             hit_rdy;
  logic [SEL_W-1:0] hit_sel;

  // Scan from oldest to nearest stage so the nearest match overwrites older ones; r0 never matches
  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_sel = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (stg_wr[k] && (src != '0) && (stg_dst[k*REG_W +: REG_W] == src)) begin
        hit     = 1'b1;
        hit_rdy = stg_rdy[k];
        hit_sel = SEL_W'(k + FWD_SEL_STAGE0);
      end
    end
  end

  assign sel   = (hit && hit_rdy && (want || need)) ? hit_sel : SEL_W'(FWD_SEL_RF);
  assign stall = need && (hit ? !hit_rdy : pending[src]);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard with forwarding select; optional HAZARD_PERF_CNT_EN stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_SRC*REG_W-1:0]              id_src,
  input  logic [NUM_SRC-1:0]                    id_want,
  input  logic [NUM_SRC-1:0]                    id_need,
  input  logic                                  id_issue,
  input  logic                                  id_long,
  input  logic [REG_W-1:0]                      id_dst,
  input  logic [NUM_FWD-1:0]                    stg_wr,
  input  logic [NUM_FWD*REG_W-1:0]              stg_dst,
  input  logic [NUM_FWD-1:0]                    stg_rdy,
  input  logic                                  lop_done,
  input  logic [REG_W-1:0]                      lop_dst,
  input  logic                                  flush,
  output logic                                  id_stall,
  output logic [NUM_SRC*$clog2(NUM_FWD+1)-1:0]  fwd_sel,
  output logic                                  hz_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_stall_cnt
`endif
);

  localparam int SEL_W = fwd_sel_width(NUM_FWD);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CNT_W-1:0]    out_cnt;
  logic [CNT_W-1:0]    out_cnt_nxt;
  logic [WD_W-1:0]     wd_cnt;
  logic [NUM_SRC-1:0]  port_stall;
  logic                long_stall;
  logic                do_set;
  logic                do_clr;

  genvar p;
  generate
    for (p = 0; p < NUM_SRC; p++) begin : g_port
      hazard_src_match #(
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
      ) u_match (
        .src     (id_src[p*REG_W +: REG_W]),
        .want    (id_want[p]),
        .need    (id_need[p]),
        .stg_wr  (stg_wr),
        .stg_dst (stg_dst),
        .stg_rdy (stg_rdy),
        .pending (pending),
        .sel     (fwd_sel[p*SEL_W +: SEL_W]),
        .stall   (port_stall[p])
      );
    end
  endgenerate

  // A long issue waits on a WAW against an in-flight write or on a full outstanding table
  assign long_stall = id_issue && id_long && (pending[id_dst] || (out_cnt == CNT_W'(MAX_OUT)));
  assign id_stall   = (|port_stall) || long_stall;

  assign do_set = id_issue && id_long && !id_stall && (id_dst != '0);
  assign do_clr = lop_done && pending[lop_dst];

  // Next pending vector and outstanding count; the set is applied last so it wins a same-register clear
  always_comb begin
    pending_nxt          = pending;
    out_cnt_nxt          = out_cnt;
    if (do_clr) pending_nxt[lop_dst] = 1'b0;
    if (do_set) pending_nxt[id_dst]  = 1'b1;
    pending_nxt[0]       = 1'b0;
    if (do_set && !do_clr && (out_cnt != CNT_W'(MAX_OUT))) begin
      out_cnt_nxt = out_cnt + 1'b1;
    end else if (!do_set && do_clr && (out_cnt != '0)) begin
      out_cnt_nxt = out_cnt - 1'b1;
    end
  end

  // Scoreboard state; flush discards everything including a same-cycle set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      out_cnt <= '0;
    end else if (flush) begin
      pending <= '0;
      out_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      out_cnt <= out_cnt_nxt;
    end
  end

  // Watchdog over consecutive stall cycles; the timeout flag is sticky until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt     <= '0;
      hz_timeout <= 1'b0;
    end else if (id_stall) begin
      if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_W'(TIMEOUT - 1)) hz_timeout <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of all stall cycles since reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
    end else if (id_stall && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 3;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 1024;
  localparam int SEL_W   = 2;

  logic                       clock = 1'b0;
  logic                       reset_n;
  logic [NUM_SRC*5-1:0]       id_src;
  logic [NUM_SRC-1:0]         id_want;
  logic [NUM_SRC-1:0]         id_need;
  logic                       id_issue;
  logic                       id_long;
  logic [4:0]                 id_dst;
  logic [NUM_FWD-1:0]         stg_wr;
  logic [NUM_FWD*5-1:0]       stg_dst;
  logic [NUM_FWD-1:0]         stg_rdy;
  logic                       lop_done;
  logic [4:0]                 lop_dst;
  logic                       flush;
  logic                       id_stall;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       hz_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]                perf_stall_cnt;
`endif

  hazard_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .NUM_FWD (NUM_FWD),
    .MAX_OUT (MAX_OUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .id_src     (id_src),
    .id_want    (id_want),
    .id_need    (id_need),
    .id_issue   (id_issue),
    .id_long    (id_long),
    .id_dst     (id_dst),
    .stg_wr     (stg_wr),
    .stg_dst    (stg_dst),
    .stg_rdy    (stg_rdy),
    .lop_done   (lop_done),
    .lop_dst    (lop_dst),
    .flush      (flush),
    .id_stall   (id_stall),
    .fwd_sel    (fwd_sel),
    .hz_timeout (hz_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    id_src   = '0;
    id_want  = '0;
    id_need  = '0;
    id_issue = 1'b0;
    id_long  = 1'b0;
    id_dst   = '0;
    stg_wr   = '0;
    stg_dst  = '0;
    stg_rdy  = '0;
    lop_done = 1'b0;
    lop_dst  = '0;
    flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic issue_long(input logic [4:0] d);
    id_issue = 1'b1;
    id_long  = 1'b1;
    id_dst   = d;
  endtask

  // Reference model: set of registers with an in-flight long write
  bit pend[32];
  int wd_ref;
  bit hz_ref;
  longint perf_ref;

  function automatic int ref_outstanding();
    int n = 0;
    foreach (pend[i]) if (pend[i]) n++;
    return n;
  endfunction

  function automatic int ref_sel(int p);
    int src = int'(id_src[p*5 +: 5]);
    if (src == 0) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (stg_wr[k] && int'(stg_dst[k*5 +: 5]) == src)
        return (stg_rdy[k] && (id_want[p] || id_need[p])) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic bit ref_port_stall(int p);
    int src = int'(id_src[p*5 +: 5]);
    if (!id_need[p] || src == 0) return 1'b0;
    for (int k = 0; k < NUM_FWD; k++)
      if (stg_wr[k] && int'(stg_dst[k*5 +: 5]) == src)
        return !stg_rdy[k];
    return pend[src];
  endfunction

  function automatic bit ref_stall();
    bit s = 1'b0;
    for (int p = 0; p < NUM_SRC; p++) s |= ref_port_stall(p);
    if (id_issue && id_long && (pend[id_dst] || ref_outstanding() == MAX_OUT)) s = 1'b1;
    return s;
  endfunction

  task automatic ref_commit(input bit stall);
    if (flush) begin
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      if (lop_done) pend[lop_dst] = 1'b0;
      if (id_issue && id_long && !stall && id_dst != 0) pend[id_dst] = 1'b1;
    end
    if (stall) begin
      wd_ref++;
      if (wd_ref >= TIMEOUT) hz_ref = 1'b1;
      if (perf_ref < 64'hFFFF_FFFF) perf_ref++;
    end else begin
      wd_ref = 0;
    end
  endtask

  typedef struct {
    logic [4:0] src0;
    logic [4:0] src1;
    logic [1:0] want;
    logic [1:0] need;
    logic [2:0] wr;
    logic [4:0] d2;
    logic [4:0] d1;
    logic [4:0] d0;
    logic [2:0] rdy;
    int         sel0;
    int         sel1;
    int         stall;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit exp_s;

    tbl[0]  = '{5'd5, 5'd0, 2'b01, 2'b00, 3'b001, 5'd0, 5'd0, 5'd5, 3'b001, 1, 0, 0};
    tbl[1]  = '{5'd5, 5'd0, 2'b00, 2'b01, 3'b011, 5'd0, 5'd5, 5'd5, 3'b010, 0, 0, 1};
    tbl[2]  = '{5'd5, 5'd0, 2'b00, 2'b01, 3'b111, 5'd5, 5'd5, 5'd5, 3'b111, 1, 0, 0};
    tbl[3]  = '{5'd7, 5'd0, 2'b01, 2'b00, 3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 2, 0, 0};
    tbl[4]  = '{5'd0, 5'd9, 2'b00, 2'b10, 3'b100, 5'd9, 5'd0, 5'd0, 3'b100, 0, 3, 0};
    tbl[5]  = '{5'd5, 5'd0, 2'b01, 2'b00, 3'b001, 5'd0, 5'd0, 5'd5, 3'b000, 0, 0, 0};
    tbl[6]  = '{5'd0, 5'd0, 2'b00, 2'b01, 3'b001, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0};
    tbl[7]  = '{5'd5, 5'd0, 2'b00, 2'b00, 3'b001, 5'd0, 5'd0, 5'd5, 3'b001, 0, 0, 0};
    tbl[8]  = '{5'd4, 5'd6, 2'b11, 2'b00, 3'b011, 5'd0, 5'd4, 5'd6, 3'b011, 2, 1, 0};
    tbl[9]  = '{5'd5, 5'd0, 2'b00, 2'b01, 3'b000, 5'd0, 5'd0, 5'd5, 3'b001, 0, 0, 0};
    tbl[10] = '{5'd0, 5'd3, 2'b00, 2'b10, 3'b001, 5'd0, 5'd0, 5'd3, 3'b000, 0, 0, 1};

    idle();
    reset_n = 1'b0;
    id_src  = {5'd0, 5'd5};
    id_need = 2'b01;
    #2;
    check("reset_stall", int'(id_stall), 0);
    check("reset_fwd_sel", int'(fwd_sel), 0);
    check("reset_timeout", int'(hz_timeout), 0);
    do_reset();

    // Combinational forwarding table with an empty scoreboard
    for (int i = 0; i < 11; i++) begin
      id_src  = {tbl[i].src1, tbl[i].src0};
      id_want = tbl[i].want;
      id_need = tbl[i].need;
      stg_wr  = tbl[i].wr;
      stg_dst = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      stg_rdy = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_sel0", i), int'(fwd_sel[0 +: SEL_W]), tbl[i].sel0);
      check($sformatf("tbl%0d_sel1", i), int'(fwd_sel[SEL_W +: SEL_W]), tbl[i].sel1);
      check($sformatf("tbl%0d_stall", i), int'(id_stall), tbl[i].stall);
    end

    // Long write to r8 blocks a needing reader until the completion edge
    do_reset();
    issue_long(5'd8);
    #1 check("a_issue", int'(id_stall), 0);
    step();
    idle();
    id_src  = {5'd0, 5'd8};
    id_need = 2'b01;
    #1 check("a_wait", int'(id_stall), 1);
    repeat (3) begin
      step();
      check("a_hold", int'(id_stall), 1);
    end
    lop_done = 1'b1;
    lop_dst  = 5'd8;
    #1 check("a_done_cycle", int'(id_stall), 1);
    step();
    lop_done = 1'b0;
    #1 check("a_release", int'(id_stall), 0);

    // Outstanding limit: fifth long issue waits for a completion
    do_reset();
    for (int d = 1; d <= 4; d++) begin
      issue_long(5'(d));
      #1 check($sformatf("b_issue%0d", d), int'(id_stall), 0);
      step();
    end
    issue_long(5'd5);
    #1 check("b_full", int'(id_stall), 1);
    step();
    check("b_full_hold", int'(id_stall), 1);
    lop_done = 1'b1;
    lop_dst  = 5'd1;
    #1 check("b_done_cycle", int'(id_stall), 1);
    step();
    lop_done = 1'b0;
    #1 check("b_proceed", int'(id_stall), 0);
    step();
    idle();
    id_src  = {5'd0, 5'd5};
    id_need = 2'b01;
    #1 check("b_dst5_pending", int'(id_stall), 1);

    // Same-cycle set/clear of r3, then flush overriding a set
    do_reset();
    issue_long(5'd3);
    lop_done = 1'b1;
    lop_dst  = 5'd3;
    #1 check("c_issue", int'(id_stall), 0);
    step();
    idle();
    id_src  = {5'd0, 5'd3};
    id_need = 2'b01;
    #1 check("c_set_wins", int'(id_stall), 1);
    id_need = 2'b00;
    issue_long(5'd20);
    flush = 1'b1;
    step();
    idle();
    id_need = 2'b01;
    id_src  = {5'd0, 5'd3};
    #1 check("c_flush_clear3", int'(id_stall), 0);
    id_src  = {5'd0, 5'd20};
    #1 check("c_flush_over_set", int'(id_stall), 0);
    idle();
    lop_done = 1'b1;
    lop_dst  = 5'd9;
    step();
    idle();
    for (int d = 10; d <= 13; d++) begin
      issue_long(5'(d));
      #1 check($sformatf("c_issue%0d", d), int'(id_stall), 0);
      step();
    end
    issue_long(5'd14);
    #1 check("c_cnt_full", int'(id_stall), 1);
    idle();

    // Watchdog: stall held for TIMEOUT cycles
    do_reset();
    issue_long(5'd8);
    step();
    idle();
    id_src  = {5'd0, 5'd8};
    id_need = 2'b01;
    repeat (TIMEOUT - 1) step();
    check("d_before_limit", int'(hz_timeout), 0);
    step();
    check("d_at_limit", int'(hz_timeout), 1);
    idle();
    lop_done = 1'b1;
    lop_dst  = 5'd8;
    step();
    lop_done = 1'b0;
    step();
    check("d_sticky", int'(hz_timeout), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("d_flush_keeps", int'(hz_timeout), 1);
    reset_n = 1'b0;
    #1 check("d_reset_clears", int'(hz_timeout), 0);

    // Reset mid-operation discards the in-flight write
    do_reset();
    issue_long(5'd8);
    step();
    idle();
    id_src  = {5'd0, 5'd8};
    id_need = 2'b01;
    #1 check("e_pre_reset", int'(id_stall), 1);
    reset_n = 1'b0;
    #1 check("e_reset_stall", int'(id_stall), 0);
    check("e_reset_fwd", int'(fwd_sel), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1 check("e_after_reset", int'(id_stall), 0);
    idle();
    lop_done = 1'b1;
    lop_dst  = 5'd8;
    step();
    idle();
    for (int d = 1; d <= 4; d++) begin
      issue_long(5'(d));
      #1 check($sformatf("e_issue%0d", d), int'(id_stall), 0);
      step();
    end
    issue_long(5'd5);
    #1 check("e_cnt_full", int'(id_stall), 1);

    // Randomized traffic against the reference model
    do_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    wd_ref   = 0;
    hz_ref   = 1'b0;
    perf_ref = 0;
    for (int c = 0; c < 3000; c++) begin
      id_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_want  = 2'($urandom);
      id_need  = 2'($urandom);
      id_issue = 1'($urandom);
      id_long  = ($urandom_range(0, 2) == 0);
      id_dst   = 5'($urandom_range(0, 7));
      stg_wr   = 3'($urandom);
      stg_dst  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_rdy  = 3'($urandom);
      lop_done = ($urandom_range(0, 3) == 0);
      lop_dst  = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 63) == 0);
      @(negedge clock);
      exp_s = ref_stall();
      check("rand_stall", int'(id_stall), int'(exp_s));
      for (int p = 0; p < NUM_SRC; p++)
        check($sformatf("rand_sel%0d", p), int'(fwd_sel[p*SEL_W +: SEL_W]), ref_sel(p));
      check("rand_timeout", int'(hz_timeout), int'(hz_ref));
      @(posedge clock);
      ref_commit(exp_s);
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cnt", int'(perf_stall_cnt), int'(perf_ref));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
